dense_node_mac: RTL and testbench



---
 rtl/nn_pkg.sv | 36 +++
 rtl/mul_2c_reg.sv | 29 ++
 rtl/dense_node_mac.sv | 116 +++++++++++
 tb/tb_dense_node_mac.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/nn_pkg.sv
// Shared types and helpers for the dense-layer neuron node.
package nn_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ACCUM,
    DRAIN,
    BIAS,
    DONE
  } node_state_t;

  localparam int DEFAULT_DATA_W    = 32;
  localparam int DEFAULT_FRAC_BITS = 0;

  // Working width of sat_trunc; wide enough for the full post-bias sum.
  localparam int SAT_W = 128;

  // Reduces a wide signed sum to data_w bits. With saturation enabled the
  // value is clamped to the signed data_w range. Otherwise it is returned
  // unchanged, and the caller keeps its low data_w bits, so it wraps around.
  function automatic logic signed [SAT_W-1:0] sat_trunc(
    input logic signed [SAT_W-1:0] r,
    input int                      data_w,
    input bit                      sat_en
  );
    logic signed [SAT_W-1:0] max_v;
    logic signed [SAT_W-1:0] min_v;
    max_v = (SAT_W'(1) <<< (data_w - 1)) - SAT_W'(1);
    min_v = -max_v - SAT_W'(1);
    if (!sat_en)        return r;
    else if (r > max_v) return max_v;
    else if (r < min_v) return min_v;
    else                return r;
  endfunction

endpackage

// File: rtl/mul_2c_reg.sv
// Registered signed DATA_W x DATA_W -> 2*DATA_W multiplier with valid pass-through.
module mul_2c_reg #(
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_vld,
  input  logic signed [DATA_W-1:0]   a,
  input  logic signed [DATA_W-1:0]   b,
  output logic signed [2*DATA_W-1:0] prod,
  output logic                       prod_vld
);

  localparam int P_W = 2 * DATA_W;

  // Capture a product on every accepted pair; the valid bit follows the input valid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod     <= '0;
      prod_vld <= 1'b0;
    end else begin
      // NOTE: all clocked state uses non-blocking assignments. Every register
      // then samples values from before the edge, whatever the statement order.
      prod_vld <= in_vld;
      if (in_vld) prod <= P_W'(a) * P_W'(b);
    end
  end

endmodule

// File: rtl/dense_node_mac.sv
// Streaming fixed-point neuron node: start + bias, N_INPUTS (x, w) pairs,
// multiply-accumulate, add the bias, then optional ReLU. The result is held
// behind an out_valid/out_ready handshake.
// Build option: define DENSE_NODE_SAT_EN to saturate the result to DATA_W.
// Without it, the result wraps around.
module dense_node_mac
  import nn_pkg::*;
#(
  parameter int DATA_W    = DEFAULT_DATA_W,
  parameter int FRAC_BITS = DEFAULT_FRAC_BITS,
  parameter int N_INPUTS  = 784,
  parameter int ACT_RELU  = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [DATA_W-1:0] bias,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_x,
  input  logic [DATA_W-1:0] in_w,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] node_res,
  output logic              busy
);

  // Sized so the sum of N_INPUTS full-scale products can never overflow.
  localparam int ACC_W = 2 * DATA_W + $clog2(N_INPUTS) + 1;
  localparam int CNT_W = $clog2(N_INPUTS + 1);
  localparam int R_W   = ACC_W + 1;

`ifdef DENSE_NODE_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  node_state_t                state, state_nxt;
  logic signed [ACC_W-1:0]    acc;
  logic        [CNT_W-1:0]    cnt;
  logic signed [DATA_W-1:0]   bias_q;
  logic signed [2*DATA_W-1:0] prod;
  logic                       prod_vld;
  logic                       xfer;
  logic                       last_xfer;
  logic signed [R_W-1:0]      r;
  logic        [DATA_W-1:0]   r_red;
  logic        [DATA_W-1:0]   res_act;

  assign in_ready  = (state == ACCUM);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign xfer      = in_valid & in_ready;
  assign last_xfer = xfer && (cnt == CNT_W'(N_INPUTS - 1));

  mul_2c_reg #(.DATA_W(DATA_W)) u_mul (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_vld   (xfer),
    .a        (in_x),
    .b        (in_w),
    .prod     (prod),
    .prod_vld (prod_vld)
  );

  // State register; reset aborts any evaluation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state sequencing through the evaluation phases.
  always_comb begin
    // NOTE: the default assignment comes before the case statement. Every path
    // then assigns state_nxt, so no latch is inferred.
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = ACCUM;
      ACCUM:   if (last_xfer) state_nxt = DRAIN;
      DRAIN:   state_nxt = BIAS;
      BIAS:    state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bias add, then reduction to DATA_W, then the optional ReLU clamp.
  always_comb begin
    r       = R_W'(acc >>> FRAC_BITS) + R_W'(bias_q);
    r_red   = DATA_W'(sat_trunc(SAT_W'(r), DATA_W, SAT_EN));
    res_act = r_red;
    if (ACT_RELU != 0 && r_red[DATA_W-1]) res_act = '0;
  end

  // Accumulator, pair counter, bias latch and result register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc      <= '0;
      cnt      <= '0;
      bias_q   <= '0;
      node_res <= '0;
    end else begin
      if (prod_vld) acc <= acc + ACC_W'(prod);
      if (xfer)     cnt <= cnt + 1'b1;
      // A new evaluation overrides the lines above. prod_vld is always low in IDLE.
      if (state == IDLE && start) begin
        bias_q <= bias;
        acc    <= '0;
        cnt    <= '0;
      end
      if (state == BIAS) node_res <= res_act;
    end
  end

endmodule

// File: tb/tb_dense_node_mac.sv
// Directed self-checking bench for dense_node_mac.
// u_relu and u_lin: DATA_W=32, N=4, fed the same stream (ACT_RELU 1 and 0).
// u_frac: DATA_W=16, FRAC_BITS=8, N=1.
module tb_dense_node_mac;

  typedef logic [31:0] vec4_t [4];

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        start, in_valid, out_ready;
  logic [31:0] bias, in_x, in_w;
  logic        in_ready_r, out_valid_r, busy_r;
  logic [31:0] res_r;
  logic        in_ready_l, out_valid_l, busy_l;
  logic [31:0] res_l;

  logic        start2, in_valid2, out_ready2;
  logic [15:0] bias2, x2, w2;
  logic        in_ready2, out_valid2, busy2;
  logic [15:0] res2;

  int n_pass  = 0;
  int n_total = 0;

  dense_node_mac #(.DATA_W(32), .FRAC_BITS(0), .N_INPUTS(4), .ACT_RELU(1)) u_relu (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready_r), .in_x(in_x), .in_w(in_w),
    .out_valid(out_valid_r), .out_ready(out_ready), .node_res(res_r), .busy(busy_r)
  );

  dense_node_mac #(.DATA_W(32), .FRAC_BITS(0), .N_INPUTS(4), .ACT_RELU(0)) u_lin (
    .clk(clk), .rst_n(rst_n), .start(start), .bias(bias),
    .in_valid(in_valid), .in_ready(in_ready_l), .in_x(in_x), .in_w(in_w),
    .out_valid(out_valid_l), .out_ready(out_ready), .node_res(res_l), .busy(busy_l)
  );

  dense_node_mac #(.DATA_W(16), .FRAC_BITS(8), .N_INPUTS(1), .ACT_RELU(1)) u_frac (
    .clk(clk), .rst_n(rst_n), .start(start2), .bias(bias2),
    .in_valid(in_valid2), .in_ready(in_ready2), .in_x(x2), .in_w(w2),
    .out_valid(out_valid2), .out_ready(out_ready2), .node_res(res2), .busy(busy2)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // One full N=4 evaluation on u_relu/u_lin, ending with the result on the outputs.
  task automatic run4(input string tag, input vec4_t xs, input vec4_t ws,
                      input logic [31:0] b, input logic [31:0] e_relu,
                      input logic [31:0] e_lin, input bit gaps);
    start = 1'b1;
    bias  = b;
    tick;
    start = 1'b0;
    check({tag, ".rdy"},  32'(in_ready_r), 32'd1);
    check({tag, ".busy"}, 32'(busy_l),     32'd1);
    for (int i = 0; i < 4; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_x     = $urandom;
          in_w     = $urandom;
          tick;
        end
      end
      in_valid = 1'b1;
      in_x     = xs[i];
      in_w     = ws[i];
      tick;
    end
    // The last transfer has just happened. Pairs offered from here on must be ignored.
    in_x = 32'd99;
    in_w = 32'd99;
    check({tag, ".drain_rdy"}, 32'(in_ready_r),  32'd0);
    check({tag, ".k_ov"},      32'(out_valid_r), 32'd0);
    tick;
    in_valid = 1'b0;
    check({tag, ".k1_ov"},     32'(out_valid_r), 32'd0);
    tick;
    check({tag, ".k2_ov"},     32'(out_valid_r), 32'd1);
    check({tag, ".res_relu"},  res_r,            e_relu);
    check({tag, ".k2_ov_l"},   32'(out_valid_l), 32'd1);
    check({tag, ".res_lin"},   res_l,            e_lin);
  endtask

  task automatic release_out(input string tag);
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
    check({tag, ".ov_drop"}, 32'(out_valid_r), 32'd0);
    check({tag, ".idle"},    32'(busy_r),      32'd0);
    check({tag, ".idle_l"},  32'(busy_l),      32'd0);
  endtask

  initial begin
    logic [31:0] ovf_exp;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    bias = '0; in_x = '0; in_w = '0;
    start2 = 1'b0; in_valid2 = 1'b0; out_ready2 = 1'b0;
    bias2 = '0; x2 = '0; w2 = '0;
    #12;
    check("rst.rdy",  32'(in_ready_r),  32'd0);
    check("rst.ov",   32'(out_valid_r), 32'd0);
    check("rst.busy", 32'(busy_r),      32'd0);
    check("rst.res",  res_r,            32'd0);
    check("rst.res2", 32'(res2),        32'd0);
    rst_n = 1'b1;
    tick;

    // Case 1: 5+12+21+32 = 70, + bias 10 = 80.
    run4("c1", '{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8},
         32'd10, 32'd80, 32'd80, 1'b0);
    release_out("c1");

    // Negative sum: -20 + 3 = -17.
    run4("neg", '{32'd1, 32'd1, 32'd1, 32'd1},
         '{32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB, 32'hFFFF_FFFB},
         32'd3, 32'd0, 32'hFFFF_FFEF, 1'b0);
    release_out("neg");

    // Input gaps, then output back-pressure with an ignored start.
    run4("gap", '{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8},
         32'd10, 32'd80, 32'd80, 1'b1);
    for (int i = 0; i < 5; i++) begin
      start    = (i == 2);
      bias     = 32'd1234;
      in_valid = 1'b1;
      in_x     = 32'd7;
      in_w     = 32'd7;
      tick;
      check("bp.res", res_r,            32'd80);
      check("bp.rdy", 32'(in_ready_r),  32'd0);
      check("bp.ov",  32'(out_valid_r), 32'd1);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    release_out("bp");

    // Overflow: 4 * (2^31-1)^2 = 2^64 - 2^34 + 4.
`ifdef DENSE_NODE_SAT_EN
    ovf_exp = 32'h7FFF_FFFF;
`else
    ovf_exp = 32'h0000_0004;
`endif
    run4("ovf", '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
         '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFF},
         32'd0, ovf_exp, ovf_exp, 1'b0);
    release_out("ovf");

    // Reset after 2 of 4 transfers.
    start = 1'b1;
    bias  = 32'd10;
    tick;
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      in_valid = 1'b1;
      in_x     = 32'(i + 1);
      in_w     = 32'(i + 5);
      tick;
    end
    in_valid = 1'b0;
    rst_n    = 1'b0;
    #1;
    check("mid.rdy",  32'(in_ready_r),  32'd0);
    check("mid.ov",   32'(out_valid_r), 32'd0);
    check("mid.busy", 32'(busy_r),      32'd0);
    check("mid.res",  res_r,            32'd0);
    #2;
    rst_n = 1'b1;
    tick;
    run4("post", '{32'd1, 32'd2, 32'd3, 32'd4}, '{32'd5, 32'd6, 32'd7, 32'd8},
         32'd10, 32'd80, 32'd80, 1'b0);
    release_out("post");

    // Q8.8: 1.5 * 2.0 + 1.0 = 4.0.
    start2 = 1'b1;
    bias2  = 16'h0100;
    tick;
    start2 = 1'b0;
    check("frac.rdy", 32'(in_ready2), 32'd1);
    in_valid2 = 1'b1;
    x2        = 16'h0180;
    w2        = 16'h0200;
    tick;
    in_valid2 = 1'b0;
    tick;
    check("frac.k1_ov", 32'(out_valid2), 32'd0);
    tick;
    check("frac.ov",  32'(out_valid2), 32'd1);
    check("frac.res", 32'(res2),       32'h0000_0400);
    out_ready2 = 1'b1;
    tick;
    out_ready2 = 1'b0;
    check("frac.drop", 32'(out_valid2), 32'd0);
    check("frac.idle", 32'(busy2),      32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
